apb_gpio: RTL and testbench



---
 rtl/apb_gpio_pkg.sv | 32 +++
 rtl/apb_gpio_sync.sv | 30 +++
 rtl/apb_gpio.sv | 156 +++++++++++++++
 tb/tb_apb_gpio.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO block: register indices and byte-strobe merge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package apb_gpio_pkg;

    // Register indices, decoded from paddr
    localparam logic [3:0] MODE      = 4'd0;
    localparam logic [3:0] DIRECTION = 4'd1;
    localparam logic [3:0] OUTPUT    = 4'd2;
    localparam logic [3:0] INPUT     = 4'd3;
    localparam logic [3:0] TR_TYPE   = 4'd4;
    localparam logic [3:0] TR_LVL0   = 4'd5;
    localparam logic [3:0] TR_LVL1   = 4'd6;
    localparam logic [3:0] TR_STAT   = 4'd7;
    localparam logic [3:0] IRQ_ENA   = 4'd8;

    // Replace each byte of cur with the matching byte of wdat where its strobe is set.
    // Works on the maximum 32-bit width; narrower instances zero-extend.
    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_gpio_sync.sv
// Two-flop synchroniser for asynchronous pad inputs.
// Latency: 2 clk_i edges from d_i to q_o. Backpressure: none.
// Ports: clk_i clock, rst_i async active-high reset, d_i async input, q_o synchronised output.
module apb_gpio_sync
    import apb_gpio_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/apb_gpio.sv
// APB4 GPIO slave: per-pin direction, push-pull/open-drain drive, level/edge interrupts.
// Latency: zero-wait-state APB (pready=1); prddata registered in setup phase; inputs 2 cycles.
// Backpressure: none, every transfer completes immediately and never errors.
// Ports: APB slave (pclk, prstn active-high async, psel..pslverr), pads gpio_i/gpio_o/gpio_oe, irq_o.
module apb_gpio
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_PINS = 32
) (
    input  logic                   pclk,
    input  logic                   prstn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic [3:0]             paddr,
    input  logic                   pwrite,
    input  logic [GPIO_PINS/8-1:0] pstrb,
    input  logic [GPIO_PINS-1:0]   pwrdata,
    output logic [GPIO_PINS-1:0]   prddata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic [GPIO_PINS-1:0]   gpio_i,
    output logic [GPIO_PINS-1:0]   gpio_o,
    output logic [GPIO_PINS-1:0]   gpio_oe,
    output logic                   irq_o
);

    logic [GPIO_PINS-1:0] mode_q, mode_d;
    logic [GPIO_PINS-1:0] dir_q,  dir_d;
    logic [GPIO_PINS-1:0] out_q,  out_d;
    logic [GPIO_PINS-1:0] type_q, type_d;
    logic [GPIO_PINS-1:0] lvl0_q, lvl0_d;
    logic [GPIO_PINS-1:0] lvl1_q, lvl1_d;
    logic [GPIO_PINS-1:0] stat_q, stat_d;
    logic [GPIO_PINS-1:0] ena_q,  ena_d;
    logic [GPIO_PINS-1:0] prev_q;
    logic [GPIO_PINS-1:0] rdata_q, rdata_d;
    logic                 irq_q;

    logic [GPIO_PINS-1:0] sync_w;
    logic [GPIO_PINS-1:0] detect;
    logic [GPIO_PINS-1:0] clr;
    logic [31:0]          wdat32;
    logic [3:0]           strb4;
    logic                 wr_en;
    logic                 rd_en;

    apb_gpio_sync #(.WIDTH(GPIO_PINS)) u_sync (
        .clk_i (pclk),
        .rst_i (prstn),
        .d_i   (gpio_i),
        .q_o   (sync_w)
    );

    assign wr_en = psel & penable & pwrite;
    assign rd_en = psel & ~penable & ~pwrite;

    // Byte-strobe merge at this instance's width
    function automatic logic [GPIO_PINS-1:0] merge(input logic [GPIO_PINS-1:0] cur,
                                                   input logic [31:0]          wd,
                                                   input logic [3:0]           st);
        logic [31:0] c32;
        c32 = '0;
        c32[GPIO_PINS-1:0] = cur;
        c32 = strb_merge(c32, wd, st);
        return c32[GPIO_PINS-1:0];
    endfunction

    always_comb begin
        wdat32 = '0;
        wdat32[GPIO_PINS-1:0] = pwrdata;
        strb4 = '0;
        strb4[GPIO_PINS/8-1:0] = pstrb;
    end

    // Level mode looks at sync only; edge mode also needs prev to see a transition.
    assign detect = (~type_q & ((lvl1_q & sync_w) | (lvl0_q & ~sync_w)))
                  | ( type_q & ((lvl1_q & sync_w & ~prev_q) | (lvl0_q & ~sync_w & prev_q)));

    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        out_d   = out_q;
        type_d  = type_q;
        lvl0_d  = lvl0_q;
        lvl1_d  = lvl1_q;
        ena_d   = ena_q;
        clr     = '0;
        rdata_d = rdata_q;
        if (wr_en) begin
            case (paddr)
                MODE:      mode_d = merge(mode_q, wdat32, strb4);
                DIRECTION: dir_d  = merge(dir_q,  wdat32, strb4);
                OUTPUT:    out_d  = merge(out_q,  wdat32, strb4);
                TR_TYPE:   type_d = merge(type_q, wdat32, strb4);
                TR_LVL0:   lvl0_d = merge(lvl0_q, wdat32, strb4);
                TR_LVL1:   lvl1_d = merge(lvl1_q, wdat32, strb4);
                TR_STAT:   clr    = merge('0,     wdat32, strb4);
                IRQ_ENA:   ena_d  = merge(ena_q,  wdat32, strb4);
                default:   ;
            endcase
        end
        // A detect in the same cycle as a clear keeps the bit set
        stat_d = (stat_q & ~clr) | detect;
        if (rd_en) begin
            case (paddr)
                MODE:      rdata_d = mode_q;
                DIRECTION: rdata_d = dir_q;
                OUTPUT:    rdata_d = out_q;
                INPUT:     rdata_d = sync_w;
                TR_TYPE:   rdata_d = type_q;
                TR_LVL0:   rdata_d = lvl0_q;
                TR_LVL1:   rdata_d = lvl1_q;
                TR_STAT:   rdata_d = stat_q;
                IRQ_ENA:   rdata_d = ena_q;
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge prstn) begin
        if (prstn) begin
            mode_q  <= '0;
            dir_q   <= '0;
            out_q   <= '0;
            type_q  <= '0;
            lvl0_q  <= '0;
            lvl1_q  <= '0;
            stat_q  <= '0;
            ena_q   <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            type_q  <= type_d;
            lvl0_q  <= lvl0_d;
            lvl1_q  <= lvl1_d;
            stat_q  <= stat_d;
            ena_q   <= ena_d;
            prev_q  <= sync_w;
            rdata_q <= rdata_d;
            irq_q   <= |(stat_q & ena_q);
        end
    end

    // Open-drain pins never drive high: they release (oe=0) for a 1 and pull low for a 0.
    assign gpio_o  = out_q & ~mode_q;
    assign gpio_oe = dir_q & ~(mode_q & out_q);
    assign prddata = rdata_q;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_apb_gpio.sv
module tb_apb_gpio;

    logic        pclk = 1'b0;
    logic        prstn;
    logic        psel;
    logic        penable;
    logic [3:0]  paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwrdata;
    logic [31:0] prddata;
    logic        pready;
    logic        pslverr;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    // Reference model: register image indexed by paddr
    logic [31:0] m [0:15];

    apb_gpio #(.GPIO_PINS(32)) dut (
        .pclk    (pclk),
        .prstn   (prstn),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pstrb   (pstrb),
        .pwrdata (pwrdata),
        .prddata (prddata),
        .pready  (pready),
        .pslverr (pslverr),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwrdata = d; pstrb = s;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        d = prddata;
        check("pready", {31'd0, pready}, 32'd1);
        check("pslverr", {31'd0, pslverr}, 32'd0);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pstrb = '0; pwrdata = '0;
        prstn = 1'b1;
        repeat (2) @(negedge pclk);
        prstn = 1'b0;
        @(negedge pclk);
        for (int i = 0; i < 16; i++) m[i] = '0;
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    initial begin
        logic [31:0] rd;
        logic [3:0]  idx;
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  rw_idx [7];
        rw_idx = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8};
        gpio_i = '0;

        // 1. reset state
        do_reset();
        check("rst_gpio_o", gpio_o, 32'h0);
        check("rst_gpio_oe", gpio_oe, 32'h0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_prddata", prddata, 32'h0);
        for (int i = 0; i <= 8; i++) begin
            apb_read(4'(i), rd);
            check($sformatf("rst_read_%0d", i), rd, 32'h0);
        end
        apb_write(4'd12, 32'hDEAD_BEEF, 4'hF);
        apb_read(4'd12, rd);
        check("unmapped_read", rd, 32'h0);

        // 2. push-pull then open-drain on low byte
        apb_write(4'd1, 32'hFFFF_FFFF, 4'hF);
        apb_write(4'd2, 32'hA5A5_5A5A, 4'hF);
        check("pp_gpio_o", gpio_o, 32'hA5A5_5A5A);
        check("pp_gpio_oe", gpio_oe, 32'hFFFF_FFFF);
        apb_write(4'd0, 32'h0000_00FF, 4'hF);
        check("od_gpio_o", gpio_o, 32'hA5A5_5A00);
        check("od_gpio_oe", gpio_oe, 32'hFFFF_FFA5);

        // 3. byte strobe
        do_reset();
        apb_write(4'd2, 32'hFFFF_FFFF, 4'b0010);
        apb_read(4'd2, rd);
        check("strb_output", rd, 32'h0000_FF00);

        // 4. input latency and read-only INPUT
        gpio_i = 32'h1234_5678;
        apb_read(4'd3, rd);
        check("input_early", rd, 32'h0);
        apb_read(4'd3, rd);
        check("input_sync", rd, 32'h1234_5678);
        apb_write(4'd3, 32'hFFFF_FFFF, 4'hF);
        apb_read(4'd3, rd);
        check("input_ro", rd, 32'h1234_5678);

        // 5. rising-edge trigger on pin 0
        gpio_i = '0;
        do_reset();
        apb_write(4'd4, 32'h1, 4'hF);
        apb_write(4'd6, 32'h1, 4'hF);
        apb_write(4'd8, 32'h1, 4'hF);
        repeat (3) @(negedge pclk);
        check("edge_idle_irq", {31'd0, irq_o}, 32'd0);
        gpio_i[0] = 1'b1;
        repeat (4) @(negedge pclk);
        check("edge_irq_rise", {31'd0, irq_o}, 32'd1);
        apb_read(4'd7, rd);
        check("edge_stat", rd, 32'h1);
        apb_write(4'd7, 32'h1, 4'hF);
        check("edge_irq_hold", {31'd0, irq_o}, 32'd1);
        @(negedge pclk);
        check("edge_irq_fall", {31'd0, irq_o}, 32'd0);
        apb_read(4'd7, rd);
        check("edge_stat_clr", rd, 32'h0);
        gpio_i[0] = 1'b0;
        repeat (4) @(negedge pclk);
        apb_read(4'd7, rd);
        check("edge_fall_ignored", rd, 32'h0);
        check("edge_fall_irq", {31'd0, irq_o}, 32'd0);

        // 6. low-level trigger on pin 3
        do_reset();
        apb_write(4'd5, 32'h8, 4'hF);
        repeat (2) @(negedge pclk);
        apb_read(4'd7, rd);
        check("lvl_stat", rd, 32'h8);
        apb_write(4'd7, 32'h8, 4'hF);
        apb_read(4'd7, rd);
        check("lvl_retrigger", rd, 32'h8);
        check("lvl_irq_masked", {31'd0, irq_o}, 32'd0);
        apb_write(4'd8, 32'h8, 4'hF);
        repeat (2) @(negedge pclk);
        check("lvl_irq_ena", {31'd0, irq_o}, 32'd1);

        // Randomised register traffic against the model
        do_reset();
        for (int it = 0; it < 60; it++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       idx = 4'd3;
                1:       idx = 4'($urandom_range(9, 15));
                default: idx = rw_idx[$urandom_range(0, 6)];
            endcase
            apb_write(idx, d, s);
            if (idx != 4'd3 && idx <= 4'd8)
                m[idx] = (m[idx] & ~strb_mask(s)) | (d & strb_mask(s));
            check("rnd_gpio_o", gpio_o, m[2] & ~m[0]);
            check("rnd_gpio_oe", gpio_oe, m[1] & ~(m[0] & m[2]));
            if (it % 6 == 5) begin
                for (int k = 0; k < 7; k++) begin
                    apb_read(rw_idx[k], rd);
                    check($sformatf("rnd_read_%0d", rw_idx[k]), rd, m[rw_idx[k]]);
                end
                gpio_i = $urandom;
                repeat (2) @(negedge pclk);
                apb_read(4'd3, rd);
                check("rnd_input", rd, gpio_i);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
